keypad_col_scan_driver: RTL and testbench

- Transmit side of the 3x4 keypad matrix: drives the three column lines active-low, one at a time.
- Generates the shared active-low sync strobe consumed by the per-row button filter bank.
- Samples that bank's 4-bit filtered row vector for each column and assembles a 12-bit frame.
- Emits one-cycle key events (code 0..11) plus held/multi-press status to the application logic.

---
 rtl/keypad_pkg.sv | 44 ++++
 rtl/keypad_col_scan_driver_if.sv | 36 +++
 rtl/keypad_frame_eval.sv | 24 ++
 rtl/keypad_col_scan_driver.sv | 172 +++++++++++++++++
 tb/tb_keypad_col_scan_driver.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and types for the 3x4 keypad column scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int KEY_W    = 4;
    localparam int FRAME_W  = NUM_ROWS * NUM_COLS;

    localparam logic [KEY_W-1:0] KEY_STAR = 4'd9;
    localparam logic [KEY_W-1:0] KEY_ZERO = 4'd10;
    localparam logic [KEY_W-1:0] KEY_HASH = 4'd11;

    typedef logic [1:0] col_idx_t;

    localparam col_idx_t COL_LAST = col_idx_t'(NUM_COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        STROBE,
        WAIT,
        SAMPLE,
        EVAL
    } state_t;

    // Saturating population count of a frame: none, exactly one, or several keys.
    typedef enum logic [1:0] {
        CNT_NONE,
        CNT_ONE,
        CNT_MULTI
    } key_count_t;

    function automatic logic [NUM_COLS-1:0] col_drive(input col_idx_t col);
        logic [NUM_COLS-1:0] v;
        v = '1;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col == col_idx_t'(c)) begin
                v[c] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/keypad_col_scan_driver_if.sv
// Signal bundle between the column scanner and its surroundings (filter bank + application).
interface keypad_col_scan_driver_if;
    import keypad_pkg::*;

    logic                  i_scan_en;
    logic [NUM_ROWS-1:0]   i_row_push;
    logic [NUM_COLS-1:0]   o_col_n;
    logic                  o_sync_n;
    logic [KEY_W-1:0]      o_key_code;
    logic                  o_key_valid;
    logic                  o_key_held;
    logic                  o_multi;

    modport master (
        output i_scan_en,
        output i_row_push,
        input  o_col_n,
        input  o_sync_n,
        input  o_key_code,
        input  o_key_valid,
        input  o_key_held,
        input  o_multi
    );

    modport slave (
        input  i_scan_en,
        input  i_row_push,
        output o_col_n,
        output o_sync_n,
        output o_key_code,
        output o_key_valid,
        output o_key_held,
        output o_multi
    );

endinterface

// File: rtl/keypad_frame_eval.sv
// Combinational frame evaluator: saturating key count and code of the (last found) pressed key.
module keypad_frame_eval
    import keypad_pkg::*;
(
    input  logic [FRAME_W-1:0] i_frame,
    output key_count_t         o_count,
    output logic [KEY_W-1:0]   o_code
);

    // Frame bit col*NUM_ROWS+row maps to key code row*NUM_COLS+col.
    always_comb begin
        o_count = CNT_NONE;
        o_code  = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (i_frame[c*NUM_ROWS + r]) begin
                    o_code  = KEY_W'(r*NUM_COLS + c);
                    o_count = (o_count == CNT_NONE) ? CNT_ONE : CNT_MULTI;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_col_scan_driver.sv
// Keypad column scanner: drives columns active-low, strobes the filter bank, assembles and evaluates frames.
module keypad_col_scan_driver
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned SAMPLE_LAT    = 2
) (
    input  logic clk,
    input  logic areset,
    keypad_col_scan_driver_if.slave bus
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_LAT) ? SETTLE_CYCLES : SAMPLE_LAT;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAT_LAST    = CNT_W'(SAMPLE_LAT - 1);

    state_t              r_state;
    state_t              w_state_next;
    col_idx_t            r_col;
    col_idx_t            w_col_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [FRAME_W-1:0]  r_frame;
    logic [NUM_COLS-1:0] r_col_n;
    logic [NUM_COLS-1:0] w_col_n_next;
    logic                r_sync_n;
    logic                w_sync_n_next;
    logic [KEY_W-1:0]    r_key_code;
    logic                r_key_valid;
    logic                r_key_held;
    logic                r_multi;
    logic [KEY_W-1:0]    r_last_key;
    logic                r_last_valid;
    key_count_t          w_count;
    logic [KEY_W-1:0]    w_code;

    keypad_frame_eval u_frame_eval (
        .i_frame (r_frame),
        .o_count (w_count),
        .o_code  (w_code)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state  <= IDLE;
            r_col    <= '0;
            r_cnt    <= '0;
            r_col_n  <= '1;
            r_sync_n <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_col    <= w_col_next;
            r_cnt    <= w_cnt_next;
            r_col_n  <= w_col_n_next;
            r_sync_n <= w_sync_n_next;
        end
    end

    // Column and strobe outputs are decoded from the next state so the registers line up with r_state.
    always_comb begin
        w_state_next  = r_state;
        w_col_next    = r_col;
        w_cnt_next    = '0;
        w_col_n_next  = '1;
        w_sync_n_next = 1'b1;

        unique case (r_state)
            IDLE: begin
                if (bus.i_scan_en) begin
                    w_state_next = DRIVE;
                    w_col_next   = '0;
                end
            end
            DRIVE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_state_next = STROBE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            STROBE: begin
                w_state_next = WAIT;
            end
            WAIT: begin
                if (r_cnt == LAT_LAST) begin
                    w_state_next = SAMPLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            SAMPLE: begin
                if (r_col == COL_LAST) begin
                    w_state_next = EVAL;
                end else begin
                    w_col_next   = r_col + 2'd1;
                    w_state_next = DRIVE;
                end
            end
            EVAL: begin
                w_col_next   = '0;
                w_state_next = bus.i_scan_en ? DRIVE : IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        unique case (w_state_next)
            DRIVE, STROBE, WAIT, SAMPLE: w_col_n_next = col_drive(w_col_next);
            default:                     w_col_n_next = '1;
        endcase

        if (w_state_next == STROBE) begin
            w_sync_n_next = 1'b0;
        end
    end

    // Each column's filtered rows land in their own nibble of the frame.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_frame <= '0;
        end else if (r_state == SAMPLE) begin
            r_frame[{r_col, 2'b00} +: NUM_ROWS] <= bus.i_row_push;
        end
    end

    // Multi-press frames freeze the reported code and last key, so a return to that same key re-arms held silently.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_key_code   <= '0;
            r_key_valid  <= 1'b0;
            r_key_held   <= 1'b0;
            r_multi      <= 1'b0;
            r_last_key   <= '0;
            r_last_valid <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (r_state == EVAL) begin
                unique case (w_count)
                    CNT_NONE: begin
                        r_key_held   <= 1'b0;
                        r_multi      <= 1'b0;
                        r_last_valid <= 1'b0;
                    end
                    CNT_ONE: begin
                        r_key_held <= 1'b1;
                        r_multi    <= 1'b0;
                        if (!r_last_valid || (w_code != r_last_key)) begin
                            r_key_code   <= w_code;
                            r_key_valid  <= 1'b1;
                            r_last_key   <= w_code;
                            r_last_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_key_held <= 1'b0;
                        r_multi    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.o_col_n     = r_col_n;
    assign bus.o_sync_n    = r_sync_n;
    assign bus.o_key_code  = r_key_code;
    assign bus.o_key_valid = r_key_valid;
    assign bus.o_key_held  = r_key_held;
    assign bus.o_multi     = r_multi;

endmodule

// File: tb/tb_keypad_col_scan_driver.sv
// Self-checking bench for keypad_col_scan_driver: table of per-frame key vectors plus directed corner sequences.
module tb_keypad_col_scan_driver;
    import keypad_pkg::*;

    localparam int unsigned SETTLE       = 4;
    localparam int unsigned LAT          = 2;
    localparam int          COL_CYCLES   = SETTLE + LAT + 2;
    localparam int          FRAME_CYCLES = 3*COL_CYCLES + 1;
    localparam int          NUM_VECS     = 12;

    typedef struct {
        logic [3:0] code;
        logic       valid;
        logic       held;
        logic       multi;
    } keys_t;

    typedef struct {
        logic [3:0] c0;
        logic [3:0] c1;
        logic [3:0] c2;
        keys_t      exp;
    } vec_t;

    logic  clk = 1'b0;
    logic  areset;
    int    checks = 0;
    int    errors = 0;
    keys_t pend;
    vec_t  vecs [NUM_VECS];

    keypad_col_scan_driver_if bus ();

    keypad_col_scan_driver #(
        .SETTLE_CYCLES (SETTLE),
        .SAMPLE_LAT    (LAT)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not reach its end");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [2:0] expColN(input int f);
        case (f / COL_CYCLES)
            0:       return 3'b110;
            1:       return 3'b101;
            2:       return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic expSyncN(input int f);
        return !((f < 3*COL_CYCLES) && ((f % COL_CYCLES) == int'(SETTLE)));
    endfunction

    // Key outputs produced by the previous EVAL are visible in the first two cycles of the following frame.
    task automatic checkPending(input int f);
        if (f == 0) begin
            checkOutput("key_code", bus.o_key_code, pend.code);
            checkOutput("key_valid", {3'b0, bus.o_key_valid}, {3'b0, pend.valid});
            checkOutput("key_held", {3'b0, bus.o_key_held}, {3'b0, pend.held});
            checkOutput("multi", {3'b0, bus.o_multi}, {3'b0, pend.multi});
        end else if (f == 1) begin
            checkOutput("key_valid_drop", {3'b0, bus.o_key_valid}, 4'h0);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_col_n", {1'b0, bus.o_col_n}, 4'h7);
        checkOutput("rst_sync_n", {3'b0, bus.o_sync_n}, 4'h1);
        checkOutput("rst_key_code", bus.o_key_code, 4'h0);
        checkOutput("rst_key_valid", {3'b0, bus.o_key_valid}, 4'h0);
        checkOutput("rst_key_held", {3'b0, bus.o_key_held}, 4'h0);
        checkOutput("rst_multi", {3'b0, bus.o_multi}, 4'h0);
    endtask

    task automatic applyStimulus(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                                 input int nCycles, input int dropAt);
        for (int f = 0; f < nCycles; f++) begin
            tick();
            case (f / COL_CYCLES)
                0:       bus.i_row_push = c0;
                1:       bus.i_row_push = c1;
                2:       bus.i_row_push = c2;
                default: bus.i_row_push = 4'h0;
            endcase
            if (f == dropAt) bus.i_scan_en = 1'b0;
            checkOutput("col_n", {1'b0, bus.o_col_n}, {1'b0, expColN(f)});
            checkOutput("sync_n", {3'b0, bus.o_sync_n}, {3'b0, expSyncN(f)});
            checkPending(f);
        end
    endtask

    initial begin
        vecs[0]  = '{4'h0, 4'h2, 4'h0, '{4'd4,  1'b1, 1'b1, 1'b0}};
        vecs[1]  = '{4'h0, 4'h2, 4'h0, '{4'd4,  1'b0, 1'b1, 1'b0}};
        vecs[2]  = '{4'h0, 4'h2, 4'h0, '{4'd4,  1'b0, 1'b1, 1'b0}};
        vecs[3]  = '{4'h0, 4'h2, 4'h0, '{4'd4,  1'b0, 1'b1, 1'b0}};
        vecs[4]  = '{4'h0, 4'h0, 4'h0, '{4'd4,  1'b0, 1'b0, 1'b0}};
        vecs[5]  = '{4'h8, 4'h0, 4'h8, '{4'd4,  1'b0, 1'b0, 1'b1}};
        vecs[6]  = '{4'h0, 4'h0, 4'h8, '{4'd11, 1'b1, 1'b1, 1'b0}};
        vecs[7]  = '{4'h0, 4'h1, 4'h8, '{4'd11, 1'b0, 1'b0, 1'b1}};
        vecs[8]  = '{4'h0, 4'h0, 4'h8, '{4'd11, 1'b0, 1'b1, 1'b0}};
        vecs[9]  = '{4'h1, 4'h0, 4'h0, '{4'd0,  1'b1, 1'b1, 1'b0}};
        vecs[10] = '{4'h0, 4'h8, 4'h0, '{4'd10, 1'b1, 1'b1, 1'b0}};
        vecs[11] = '{4'h0, 4'h0, 4'h0, '{4'd10, 1'b0, 1'b0, 1'b0}};

        areset         = 1'b1;
        bus.i_scan_en  = 1'b1;
        bus.i_row_push = 4'h0;
        repeat (3) @(negedge clk);
        checkReset();
        areset = 1'b0;
        pend   = '{4'd0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].c0, vecs[i].c1, vecs[i].c2, FRAME_CYCLES, -1);
            pend = vecs[i].exp;
        end

        // Scan enable dropped during column 1: the frame still finishes, then the scanner parks.
        applyStimulus(4'h0, 4'h0, 4'h0, FRAME_CYCLES, COL_CYCLES + 2);
        pend = '{4'd10, 1'b0, 1'b0, 1'b0};
        for (int f = 0; f < 12; f++) begin
            tick();
            checkOutput("idle_col_n", {1'b0, bus.o_col_n}, 4'h7);
            checkOutput("idle_sync_n", {3'b0, bus.o_sync_n}, 4'h1);
            checkPending(f);
        end
        bus.i_scan_en = 1'b1;

        applyStimulus(4'h0, 4'h2, 4'h0, FRAME_CYCLES, -1);
        pend = '{4'd4, 1'b1, 1'b1, 1'b0};

        // Reset hits while column 2 waits with a key pressed; the frame is abandoned without an event.
        applyStimulus(4'h0, 4'h0, 4'h4, 2*COL_CYCLES + int'(SETTLE) + 2, -1);
        #2;
        areset = 1'b1;
        #1;
        checkReset();
        @(negedge clk);
        checkOutput("rst_hold_valid", {3'b0, bus.o_key_valid}, 4'h0);
        @(negedge clk);
        areset = 1'b0;
        pend   = '{4'd0, 1'b0, 1'b0, 1'b0};

        applyStimulus(4'h0, 4'h0, 4'h0, FRAME_CYCLES, -1);
        pend = '{4'd0, 1'b0, 1'b0, 1'b0};
        applyStimulus(4'h0, 4'h2, 4'h0, FRAME_CYCLES, -1);
        pend = '{4'd4, 1'b1, 1'b1, 1'b0};
        for (int f = 0; f < 2; f++) begin
            tick();
            checkPending(f);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
